// File: rtl/pc_four_adder_pkg.sv
// Shared core constants for the PC increment path.
package pc_four_adder_pkg;

  // Architectural register / PC width
  localparam int XLEN = 32;

  // Sequential fetch step in bytes
  localparam int PC_INCREMENT = 4;

  // Value the registered trace copy takes while the core is in reset
  localparam logic [XLEN-1:0] PC_RESET = 32'h0000_0000;

endpackage : pc_four_adder_pkg

// File: rtl/pc_four_adder_const_incrementer.sv
// Constant incrementer: returns {carry, sum} of a port value plus a
// compile-time constant, computed one bit wider than the operand so the
// wrap is visible. Shared with the branch-target path.
module const_incrementer #(
  parameter int WIDTH     = 32,
  parameter int INCREMENT = 4
) (
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH:0]   result
);

  // Constant zero-extended to the full sum width
  localparam logic [WIDTH:0] INCREMENT_EXT = (WIDTH+1)'(INCREMENT);

  logic [WIDTH:0] value_ext_s;

  assign value_ext_s = {1'b0, value};
  assign result      = value_ext_s + INCREMENT_EXT;

endmodule : const_incrementer

// File: rtl/pc_four_adder.sv
// Sequential next-PC adder (PC + INCREMENT). The sum and carry are purely
// combinational so the next-PC mux sees them in the same cycle; a registered
// copy of both is kept for debug/trace and cleared by the core reset.
module pc_four_adder
  import pc_four_adder_pkg::*;
#(
  parameter int WIDTH     = XLEN,
  parameter int INCREMENT = PC_INCREMENT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] input_1,
  output logic [WIDTH-1:0] adder_output,
  output logic             carry_out,
  output logic [WIDTH-1:0] adder_output_q,
  output logic             carry_out_q
);

  // Reset value of the trace register, resized to this instance's width
  localparam logic [WIDTH-1:0] RESET_VALUE = WIDTH'(PC_RESET);

  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] adder_output_r;
  logic             carry_out_r;

  const_incrementer #(
    .WIDTH     (WIDTH),
    .INCREMENT (INCREMENT)
  ) u_const_incrementer (
    .value  (input_1),
    .result (sum_s)
  );

  // Combinational path: independent of clk and rst_n by design
  assign adder_output = sum_s[WIDTH-1:0];
  assign carry_out    = sum_s[WIDTH];

  // Trace registers: capture the sum and wrap flag each edge, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adder_output_r <= RESET_VALUE;
      carry_out_r    <= 1'b0;
    end else begin
      adder_output_r <= sum_s[WIDTH-1:0];
      carry_out_r    <= sum_s[WIDTH];
    end
  end

  assign adder_output_q = adder_output_r;
  assign carry_out_q    = carry_out_r;

endmodule : pc_four_adder

// File: tb/tb_pc_four_adder.sv
// Directed self-checking bench for pc_four_adder (WIDTH=32, INCREMENT=4).
module tb_pc_four_adder;

  logic        clk;
  logic        rst_n;
  logic [31:0] input_1;
  logic [31:0] adder_output;
  logic        carry_out;
  logic [31:0] adder_output_q;
  logic        carry_out_q;

  int compared_cnt;
  int mismatch_cnt;

  pc_four_adder dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .input_1        (input_1),
    .adder_output   (adder_output),
    .carry_out      (carry_out),
    .adder_output_q (adder_output_q),
    .carry_out_q    (carry_out_q)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared_cnt++;
    if (observed !== expected) begin
      mismatch_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Drive a value at the falling edge, check the comb outputs, then check
  // the registered copy just after the following rising edge.
  task automatic apply_vector(input logic [31:0] value, input logic [31:0] exp_sum,
                              input logic exp_carry, input string tag);
    @(negedge clk);
    input_1 = value;
    #1;
    check_value({tag, "_sum"},   {32'h0, adder_output}, {32'h0, exp_sum});
    check_value({tag, "_carry"}, {63'h0, carry_out},    {63'h0, exp_carry});
    @(posedge clk);
    #1;
    check_value({tag, "_sum_q"},   {32'h0, adder_output_q}, {32'h0, exp_sum});
    check_value({tag, "_carry_q"}, {63'h0, carry_out_q},    {63'h0, exp_carry});
  endtask

  initial begin
    logic [31:0] rnd_val;
    logic [32:0] model_sum;

    compared_cnt = 0;
    mismatch_cnt = 0;
    rst_n        = 1'b0;
    input_1      = 32'd0;

    // Reset state: registered outputs cleared, comb path still live
    #2;
    check_value("reset_sum_q",   {32'h0, adder_output_q}, 64'd0);
    check_value("reset_carry_q", {63'h0, carry_out_q},    64'd0);
    check_value("reset_comb",    {32'h0, adder_output},   64'd4);

    @(negedge clk);
    rst_n = 1'b1;

    // Ordinary increments
    apply_vector(32'd10, 32'd14, 1'b0, "v10");
    apply_vector(32'd5,  32'd9,  1'b0, "v5");
    apply_vector(32'd15, 32'd19, 1'b0, "v15");
    apply_vector(32'd0,  32'd4,  1'b0, "v0");

    // Wrap boundaries
    apply_vector(32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0, "below_wrap");
    apply_vector(32'hFFFF_FFFC, 32'h0000_0000, 1'b1, "at_wrap");
    apply_vector(32'hFFFF_FFFF, 32'h0000_0003, 1'b1, "max_in");

    // Asynchronous reset mid-cycle while input_1 = 100
    apply_vector(32'd100, 32'd104, 1'b0, "pre_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check_value("async_rst_sum_q",   {32'h0, adder_output_q}, 64'd0);
    check_value("async_rst_carry_q", {63'h0, carry_out_q},    64'd0);
    check_value("async_rst_comb",    {32'h0, adder_output},   64'd104);
    @(posedge clk);
    #1;
    check_value("rst_hold_sum_q", {32'h0, adder_output_q}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_value("post_rst_sum_q", {32'h0, adder_output_q}, 64'd104);

    // Input changes between edges: comb tracks, register holds
    @(negedge clk);
    input_1 = 32'd8;
    #1;
    check_value("mid_8_sum",   {32'h0, adder_output},   64'd12);
    check_value("mid_8_hold",  {32'h0, adder_output_q}, 64'd104);
    input_1 = 32'd12;
    #1;
    check_value("mid_12_sum",  {32'h0, adder_output},   64'd16);
    check_value("mid_12_hold", {32'h0, adder_output_q}, 64'd104);
    @(posedge clk);
    #1;
    check_value("mid_edge_sum_q", {32'h0, adder_output_q}, 64'd16);

    // Pseudo-random sweep against a 33-bit add model
    for (int i = 0; i < 1000; i++) begin
      rnd_val   = $urandom;
      if (i % 100 == 0) rnd_val = 32'hFFFF_FFFC + 32'(i % 4);
      model_sum = {1'b0, rnd_val} + 33'd4;
      apply_vector(rnd_val, model_sum[31:0], model_sum[32], "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared_cnt, mismatch_cnt);
    $finish;
  end

endmodule : tb_pc_four_adder

// File: doc/pc_four_adder.md
# pc_four_adder

Constant-increment adder producing the sequential next-PC value (PC + 4) for the single-cycle RISC-V datapath. It takes the current program-counter word and presents the incremented word combinationally, so the next-PC mux sees it within the same cycle. It also exposes a registered copy and a wrap flag for debug/trace, clocked on the core clock and cleared by the core's asynchronous active-low reset. It sits between the PC register and the next-PC select mux.

## Interface
Parameters:
- WIDTH, 32, data width of the PC word in bits.
- INCREMENT, 4, constant added to the input; must be less than 2^WIDTH.

Ports:
- clk  input  1  core clock; all registered outputs update on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- input_1  input  WIDTH  current PC value, unsigned.
- adder_output  output  WIDTH  input_1 + INCREMENT, combinational, modulo 2^WIDTH.
- carry_out  output  1  combinational; 1 when input_1 + INCREMENT ≥ 2^WIDTH, i.e. the sum wrapped.
- adder_output_q  output  WIDTH  adder_output captured at the last rising clk edge.
- carry_out_q  output  1  carry_out captured at the last rising clk edge.

## Operation
- Sum is computed as a WIDTH+1-bit unsigned add of input_1 and zero-extended INCREMENT:
  - The low WIDTH bits drive adder_output.
  - The MSB drives carry_out.
- No signed interpretation and no saturation; wrap-around is the required behaviour.
- Inputs are never rejected; there is no handshake or enable, and every value is valid.
- adder_output and carry_out depend only on input_1; they ignore clk and rst_n entirely, including during reset.
- Registered path: on each rising clk with rst_n high:
  - adder_output_q ← adder_output.
  - carry_out_q ← carry_out.

## Timing
- Combinational outputs: zero-cycle latency. They settle within the same cycle as an input_1 change and must meet single-cycle timing to the next-PC mux.
- Registered outputs: one-cycle latency from input_1 to adder_output_q/carry_out_q.
- Reset:
  - rst_n low asynchronously forces adder_output_q = 0 and carry_out_q = 0, immediately and regardless of clk.
  - Outputs hold while rst_n is low.
  - The first capture after reset is the first rising clk with rst_n high.
- Reset deasserting in the same cycle as a clk edge: deassertion is synchronised by the surrounding reset logic; this block requires no capture on that edge.
- Boundary cases:
  - input_1 = 2^WIDTH − INCREMENT − 1 gives all-ones, carry 0.
  - input_1 = 2^WIDTH − INCREMENT gives 0, carry 1.

## Structure
- The shared core package holds:
  - XLEN = 32, used as the WIDTH default.
  - PC_INCREMENT = 4, used as the INCREMENT default.
  - Reset value constant PC_RESET = 0.
- One sub-module, const_incrementer:
  - Parameterised WIDTH+1-bit adder of a port value and a constant.
  - Returns {carry, sum}.
  - Reused by the branch-target path.
- The top level instantiates const_incrementer plus the two-register output stage.

## Test plan
- Hold clk toggling at a 10-unit period, rst_n high. Apply input_1 = 10, 5, 15, 0 at 10-unit steps. Required: adder_output = 14, 9, 19, 4 and carry_out = 0 in the same step; adder_output_q follows one edge later.
- input_1 = 4294967291 (0xFFFF_FFFB) -> adder_output = 0xFFFF_FFFF, carry_out = 0.
- input_1 = 0xFFFF_FFFC -> adder_output = 0x0000_0000, carry_out = 1; next edge gives carry_out_q = 1. Repeat with input_1 = 0xFFFF_FFFF -> adder_output = 3, carry_out = 1.
- Assert rst_n low mid-cycle while input_1 = 100. Required:
  - adder_output_q and carry_out_q go to 0 immediately, without waiting for a clk edge.
  - adder_output stays 104.
  - After release, the next edge gives adder_output_q = 104.
- Change input_1 between clk edges (e.g. 8 then 12 within one cycle). Required: adder_output tracks 12 then 16 with no clock dependency; adder_output_q holds its prior value until the edge.
- Randomised input_1, 1000 vectors, compared against a (input_1 + 4) mod 2^32 model plus a carry model.
